// File: rtl/x_pcie_rx_gear_align.sv
// x_pcie_rx_gear_align: packs CTC byte stream into COM-aligned 16-bit PIPE words
module x_pcie_rx_gear_align #(
  parameter logic [7:0] COM_BYTE   = 8'hBC,
  parameter bit         REALIGN_EN = 1'b1,
  parameter int         ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 byte_en,
  input  logic [7:0]           data_in,
  input  logic                 kcntl_in,
  input  logic [2:0]           status_in,
  input  logic                 lanesync_in,
  output logic [15:0]          word_data,
  output logic [1:0]           word_kcntl,
  output logic [5:0]           word_status,
  output logic                 word_valid,
  output logic                 gear_locked,
  output logic                 realign_pulse,
  output logic [ERR_CNT_W-1:0] realign_cnt
);
  typedef enum logic [1:0] {IDLE, HUNT, LOCKED} state_t;
  state_t      r_state, w_nstate;
  logic        r_phase, w_nphase;
  logic [11:0] r_hold, w_nhold;
  logic        w_emit, w_pulse, w_inc;
  logic        w_acc, w_com;
  logic [11:0] w_in;
  assign w_acc = byte_en && lanesync_in;
  assign w_com = w_acc && kcntl_in && (data_in == COM_BYTE);
  assign w_in  = {status_in, kcntl_in, data_in};
  // next state: lane-sync loss wins, then hunt for COM, then pair bytes with odd-phase COM handling
  always_comb begin
    w_nstate = r_state;
    w_nphase = r_phase;
    w_nhold  = r_hold;
    w_emit   = 1'b0;
    w_pulse  = 1'b0;
    w_inc    = 1'b0;
    if (!lanesync_in) begin
      w_nstate = IDLE;
      w_nphase = 1'b0;
      w_nhold  = '0;
    end else begin
      case (r_state)
        IDLE: w_nstate = HUNT;
        HUNT: if (w_com) begin
          w_nhold  = w_in;
          w_nphase = 1'b1;
          w_nstate = LOCKED;
        end
        LOCKED: if (w_acc) begin
          if (!r_phase) begin
            w_nhold  = w_in;
            w_nphase = 1'b1;
          end else begin
            w_inc = w_com;
            if (w_com && REALIGN_EN) begin
              w_nhold  = w_in;
              w_pulse  = 1'b1;
            end else begin
              w_emit   = 1'b1;
              w_nphase = 1'b0;
            end
          end
        end
        default: w_nstate = IDLE;
      endcase
    end
  end
  // state, holding register and registered word/status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_phase       <= 1'b0;
      r_hold        <= '0;
      word_data     <= '0;
      word_kcntl    <= '0;
      word_status   <= '0;
      word_valid    <= 1'b0;
      gear_locked   <= 1'b0;
      realign_pulse <= 1'b0;
      realign_cnt   <= '0;
    end else begin
      r_state       <= w_nstate;
      r_phase       <= w_nphase;
      r_hold        <= w_nhold;
      word_valid    <= w_emit;
      gear_locked   <= (r_state == LOCKED);
      realign_pulse <= w_pulse;
      if (w_emit) begin
        word_data   <= {data_in, r_hold[7:0]};
        word_kcntl  <= {kcntl_in, r_hold[8]};
        word_status <= {status_in, r_hold[11:9]};
      end
      if (w_inc && !(&realign_cnt))
        realign_cnt <= realign_cnt + ERR_CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_x_pcie_rx_gear_align.sv
// tb_x_pcie_rx_gear_align: vectors, corner sequences and random stream vs a byte-pairing model
module tb_x_pcie_rx_gear_align;
  logic clk = 1'b0;
  logic rst_n, byte_en, kcntl_in, lanesync_in;
  logic [7:0] data_in;
  logic [2:0] status_in;
  logic [15:0] d0, d1;
  logic [1:0] k0, k1;
  logic [5:0] s0, s1;
  logic v0, v1, l0, l1, p0, p1;
  logic [7:0] c0, c1;
  logic [34:0] o0, o1;
  int tot = 0;
  int bad = 0;
  always #5 clk = ~clk;
  x_pcie_rx_gear_align #(.REALIGN_EN(1'b1)) u0 (.clk(clk), .rst_n(rst_n), .byte_en(byte_en), .data_in(data_in),
    .kcntl_in(kcntl_in), .status_in(status_in), .lanesync_in(lanesync_in), .word_data(d0), .word_kcntl(k0),
    .word_status(s0), .word_valid(v0), .gear_locked(l0), .realign_pulse(p0), .realign_cnt(c0));
  x_pcie_rx_gear_align #(.REALIGN_EN(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .byte_en(byte_en), .data_in(data_in),
    .kcntl_in(kcntl_in), .status_in(status_in), .lanesync_in(lanesync_in), .word_data(d1), .word_kcntl(k1),
    .word_status(s1), .word_valid(v1), .gear_locked(l1), .realign_pulse(p1), .realign_cnt(c1));
  assign o0 = {d0, k0, s0, v0, l0, p0, c0};
  assign o1 = {d1, k1, s1, v1, l1, p1, c1};
  // model: mode 0 idle / 1 hunting / 2 locked; mh says a byte is waiting for its partner
  int ms[2];
  bit mh[2];
  logic [11:0] mb[2];
  logic [15:0] mw[2];
  logic [1:0] mk[2];
  logic [5:0] mss[2];
  logic mv[2], ml[2], mp[2];
  logic [7:0] mc[2];
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    tot++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, a, e, $time);
    end
  endtask
  task automatic model(input int i);
    logic acc, com;
    logic [11:0] x;
    acc = byte_en && lanesync_in;
    com = acc && kcntl_in && data_in == 8'hBC;
    x = {status_in, kcntl_in, data_in};
    if (!rst_n) begin
      ms[i] = 0; mh[i] = 0; mb[i] = '0; mw[i] = '0; mk[i] = '0; mss[i] = '0;
      mv[i] = 0; ml[i] = 0; mp[i] = 0; mc[i] = '0;
      return;
    end
    ml[i] = (ms[i] == 2);
    mv[i] = 0;
    mp[i] = 0;
    if (!lanesync_in) begin
      ms[i] = 0;
      mh[i] = 0;
    end else if (ms[i] == 0) ms[i] = 1;
    else if (ms[i] == 1) begin
      if (com) begin mb[i] = x; mh[i] = 1; ms[i] = 2; end
    end else if (acc) begin
      if (com && mh[i] && mc[i] != 8'hFF) mc[i] = mc[i] + 8'd1;
      if (!mh[i]) begin mb[i] = x; mh[i] = 1; end
      else if (com && i == 0) begin mb[i] = x; mp[i] = 1; end
      else begin
        mw[i] = {data_in, mb[i][7:0]};
        mk[i] = {kcntl_in, mb[i][8]};
        mss[i] = {status_in, mb[i][11:9]};
        mv[i] = 1;
        mh[i] = 0;
      end
    end
  endtask
  task automatic step(input logic n, input logic en, input logic [7:0] d, input logic k,
                      input logic [2:0] s, input logic ls);
    rst_n = n; byte_en = en; data_in = d; kcntl_in = k; status_in = s; lanesync_in = ls;
    @(posedge clk);
    model(0);
    model(1);
    #1;
    chk("model_re1", o0, {mw[0], mk[0], mss[0], mv[0], ml[0], mp[0], mc[0]});
    chk("model_re0", o1, {mw[1], mk[1], mss[1], mv[1], ml[1], mp[1], mc[1]});
  endtask
  task automatic b(input logic [7:0] d, input logic k);
    step(1, 1, d, k, 3'b000, 1);
  endtask
  typedef struct {
    logic en; logic [7:0] d; logic k; logic ls;
    logic v; logic [15:0] w; logic [1:0] wk; logic lk;
  } vec_t;
  vec_t tbl[7];
  int nv;
  initial begin
    tbl[0] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0000, 2'b00, 1'b0};
    tbl[1] = '{1'b1, 8'hBC, 1'b1, 1'b1, 1'b0, 16'h0000, 2'b00, 1'b0};
    tbl[2] = '{1'b1, 8'h1C, 1'b1, 1'b1, 1'b1, 16'h1CBC, 2'b11, 1'b1};
    tbl[3] = '{1'b1, 8'h1C, 1'b1, 1'b1, 1'b0, 16'h0000, 2'b00, 1'b1};
    tbl[4] = '{1'b1, 8'h1C, 1'b1, 1'b1, 1'b1, 16'h1C1C, 2'b11, 1'b1};
    tbl[5] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0000, 2'b00, 1'b1};
    tbl[6] = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 16'h0100, 2'b00, 1'b1};
    step(0, 0, 8'h00, 0, 3'b000, 0);
    step(0, 1, 8'hBC, 1, 3'b111, 1);
    chk("reset_outputs", o0, 35'd0);
    for (int i = 0; i < 7; i++) begin
      step(1, tbl[i].en, tbl[i].d, tbl[i].k, 3'b000, tbl[i].ls);
      chk("t1_valid", v0, tbl[i].v);
      chk("t1_lock", l0, tbl[i].lk);
      if (tbl[i].v) begin
        chk("t1_word", d0, tbl[i].w);
        chk("t1_k", k0, tbl[i].wk);
      end
    end
    b(8'h55, 0);
    b(8'hBC, 1);
    chk("t2_pulse", p0, 1'b1);
    chk("t2_cnt", c0, 8'd1);
    chk("t2_novalid", v0, 1'b0);
    chk("t3_valid", v1, 1'b1);
    chk("t3_word", {d1, k1}, {16'hBC55, 2'b10});
    chk("t3_cnt", c1, 8'd1);
    chk("t3_nopulse", p1, 1'b0);
    b(8'h77, 0);
    chk("t2_word", {v0, d0}, {1'b1, 16'h77BC});
    nv = 0;
    step(1, 1, 8'hA1, 0, 3'b001, 1); nv += int'(v0);
    step(1, 0, 8'hEE, 0, 3'b010, 1); nv += int'(v0);
    step(1, 0, 8'hBC, 1, 3'b010, 1); nv += int'(v0);
    step(1, 1, 8'hB2, 0, 3'b000, 1); nv += int'(v0);
    chk("t4_count", nv, 1);
    chk("t4_word", d0, 16'hB2A1);
    chk("t4_status", s0, 6'b000001);
    b(8'h33, 0);
    step(1, 1, 8'h44, 0, 3'b000, 0);
    chk("t5_drop", v0, 1'b0);
    b(8'h55, 0);
    b(8'h55, 0);
    chk("t5_hunt", v0, 1'b0);
    b(8'hBC, 1);
    b(8'h66, 0);
    chk("t5_relock", {v0, d0}, {1'b1, 16'h66BC});
    b(8'hBC, 1);
    step(1, 1, 8'hBC, 1, 3'b000, 0);
    chk("t5_drop_com", {v0, p0, c0}, {1'b0, 1'b0, 8'd1});
    b(8'h00, 0);
    b(8'hBC, 1);
    for (int i = 0; i < 300; i++) b(8'hBC, 1);
    chk("t6_sat", c0, 8'd255);
    step(0, 1, 8'hBC, 1, 3'b000, 1);
    chk("t6_reset", o0, 35'd0);
    chk("t6_reset_re0", o1, 35'd0);
    for (int i = 0; i < 4000; i++) begin
      logic com;
      com = ($urandom_range(0, 3) == 0);
      step($urandom_range(0, 99) != 0, $urandom_range(0, 4) != 0,
           com ? 8'hBC : 8'($urandom_range(0, 255)), com ? 1'b1 : 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), $urandom_range(0, 29) != 0);
    end
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
